phase_measure_scheduler: RTL and testbench

- Time-multiplexes one shared start/stop phase detector across NUM_CH clock-pair channels.
- Steers the external clock-pair mux (ch_sel) and clears the detector while the mux settles.
- Accumulates 2**AVG_LOG2 phase tags per channel and presents one summed result per channel on a valid/ready interface.
- Sits between the detector and the readout/telemetry logic, all in the clk_sample domain.

---
 rtl/phase_measure_scheduler.sv | 166 ++++++++++++++++
 tb/tb_phase_measure_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_measure_scheduler.sv
// Round-robin scheduler that shares one start/stop phase detector across NUM_CH clock pairs.
// Optional min/max tag tracking is enabled with the PHASE_SCHED_MINMAX_EN macro.
module phase_measure_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int PHASE_W        = 28,
  parameter int AVG_LOG2       = 3,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2**20,
  localparam int CH_W  = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH),
  localparam int SUM_W = PHASE_W + AVG_LOG2,
  localparam int CNT_W = AVG_LOG2 + 1
) (
  input  logic               clk_sample,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_CH-1:0]  ch_mask,
  output logic [CH_W-1:0]    ch_sel,
  output logic               det_clear,
  input  logic [PHASE_W-1:0] phase_tag,
  input  logic               phase_tag_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CH_W-1:0]    res_ch,
  output logic [SUM_W-1:0]   res_sum,
  output logic [CNT_W-1:0]   res_count,
  output logic               res_timeout
`ifdef PHASE_SCHED_MINMAX_EN
  ,
  output logic [PHASE_W-1:0] res_min,
  output logic [PHASE_W-1:0] res_max
`endif
);

  localparam int SET_W = ($clog2(SETTLE_CYCLES) < 1) ? 1 : $clog2(SETTLE_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL        = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

  state_t            state;
  logic [CH_W-1:0]   last_ch;
  logic [SET_W-1:0]  settle_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [SUM_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;

  logic [CH_W-1:0]   base_ch;
  logic [CH_W-1:0]   nxt_ch;
  logic              pick_ok;
  logic [SUM_W-1:0]  acc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              meas_done;

  // In REPORT the channel just serviced is still on ch_sel; last_ch is only updated on the handshake.
  assign base_ch = (state == REPORT) ? ch_sel : last_ch;
  assign pick_ok = enable && (|ch_mask);

  always_comb begin
    nxt_ch = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (ch_mask[(int'(base_ch) + k) % NUM_CH])
        nxt_ch = CH_W'((int'(base_ch) + k) % NUM_CH);
    end
  end

  assign acc_d     = phase_tag_valid ? acc + SUM_W'(phase_tag) : acc;
  assign cnt_d     = phase_tag_valid ? cnt + CNT_W'(1) : cnt;
  assign meas_done = phase_tag_valid ? (cnt_d == FULL) : (to_cnt == TO_LAST);

`ifdef PHASE_SCHED_MINMAX_EN
  logic [PHASE_W-1:0] mn, mx, mn_d, mx_d;
  assign mn_d = (phase_tag_valid && phase_tag < mn) ? phase_tag : mn;
  assign mx_d = (phase_tag_valid && phase_tag > mx) ? phase_tag : mx;

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      mn      <= '1;
      mx      <= '0;
      res_min <= '1;
      res_max <= '0;
    end else if (state == SETTLE && settle_cnt == SETTLE_LAST) begin
      mn <= '1;
      mx <= '0;
    end else if (state == MEASURE) begin
      mn <= mn_d;
      mx <= mx_d;
      if (meas_done) begin
        res_min <= mn_d;
        res_max <= mx_d;
      end
    end
  end
`endif

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch_sel      <= '0;
      det_clear   <= 1'b1;
      last_ch     <= CH_W'(NUM_CH - 1);
      settle_cnt  <= '0;
      to_cnt      <= '0;
      acc         <= '0;
      cnt         <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_sum     <= '0;
      res_count   <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          det_clear <= 1'b1;
          if (pick_ok) begin
            ch_sel     <= nxt_ch;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state     <= MEASURE;
            det_clear <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            to_cnt    <= '0;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        MEASURE: begin
          acc    <= acc_d;
          cnt    <= cnt_d;
          to_cnt <= phase_tag_valid ? '0 : to_cnt + TO_W'(1);
          if (meas_done) begin
            state       <= REPORT;
            det_clear   <= 1'b1;
            res_valid   <= 1'b1;
            res_ch      <= ch_sel;
            res_sum     <= acc_d;
            res_count   <= cnt_d;
            res_timeout <= !phase_tag_valid;
          end
        end
        REPORT: begin
          det_clear <= 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            last_ch   <= ch_sel;
            if (pick_ok) begin
              ch_sel     <= nxt_ch;
              settle_cnt <= '0;
              state      <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_measure_scheduler.sv
// Directed bench for phase_measure_scheduler with a behavioural detector that strobes every other cycle.
module tb_phase_measure_scheduler;
  localparam int NUM_CH = 4;
  localparam int PW     = 28;
  localparam int SW     = PW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    ch_mask = 4'b0000;
  logic [1:0]    ch_sel;
  logic          det_clear;
  logic [PW-1:0] phase_tag = '0;
  logic          phase_tag_valid = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [1:0]    res_ch;
  logic [SW-1:0] res_sum;
  logic [3:0]    res_count;
  logic          res_timeout;
`ifdef PHASE_SCHED_MINMAX_EN
  logic [PW-1:0] res_min, res_max;
`endif

  int checks = 0;
  int failures = 0;

  phase_measure_scheduler #(.NUM_CH(NUM_CH), .PHASE_W(PW), .AVG_LOG2(3),
                            .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
    .clk_sample(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .ch_sel(ch_sel), .det_clear(det_clear), .phase_tag(phase_tag),
    .phase_tag_valid(phase_tag_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_sum(res_sum), .res_count(res_count), .res_timeout(res_timeout)
`ifdef PHASE_SCHED_MINMAX_EN
    , .res_min(res_min), .res_max(res_max)
`endif
  );

  always #5 clk = ~clk;

  // Detector model: per-channel constant tag, optional scripted sequence, silence mask, spam in REPORT.
  int   tag_val [4] = '{10, 20, 30, 40};
  int   seq_v   [8] = '{5, 9, 3, 7, 7, 7, 7, 7};
  logic [3:0] silent = 4'b0000;
  logic spam = 1'b0;
  logic use_seq = 1'b0;
  logic tick = 1'b0;
  int   seq_idx = 0;

  always @(posedge clk) begin
    #1;
    phase_tag_valid = 1'b0;
    tick = ~tick;
    if (!use_seq) seq_idx = 0;
    if (tick && ((!det_clear && !silent[ch_sel]) || spam)) begin
      phase_tag_valid = 1'b1;
      if (use_seq && !det_clear) begin
        phase_tag = PW'(seq_v[seq_idx % 8]);
        seq_idx++;
      end else begin
        phase_tag = PW'(tag_val[ch_sel]);
      end
    end
  end

  // Length of the det_clear-high run following each change of ch_sel.
  int   settle_cnt = 0;
  int   settle_len = 0;
  logic [1:0] prev_sel = 2'd0;
  logic prev_dc = 1'b1;
  always @(negedge clk) begin
    if (ch_sel != prev_sel) settle_cnt = 1;
    else if (det_clear) settle_cnt++;
    if (!det_clear && prev_dc) settle_len = settle_cnt;
    prev_sel = ch_sel;
    prev_dc  = det_clear;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_res(input int ch, input int sum, input int cnt, input int to);
    int n = 0;
    @(posedge clk);
    @(negedge clk);
    while (!res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_seen", res_valid, 1);
    chk("res_ch", res_ch, ch);
    chk("res_sum", res_sum, sum);
    chk("res_count", res_count, cnt);
    chk("res_timeout", res_timeout, to);
  endtask

  task automatic wait_measure();
    int n = 0;
    while (det_clear && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("measure_entered", det_clear, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_det_clear", det_clear, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_ch", res_ch, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_timeout", res_timeout, 0);
  endtask

  initial begin
    // Reset state
    enable  = 1'b1;
    ch_mask = 4'b1111;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // Full round robin
    wait_res(0, 80, 8, 0);
    wait_res(1, 160, 8, 0);
    wait_res(2, 240, 8, 0);
    wait_res(3, 320, 8, 0);
    wait_res(0, 80, 8, 0);
    ch_mask = 4'b1010;

    // Sparse mask: alternate ch1/ch3, 16 settle cycles after each switch
    wait_res(1, 160, 8, 0);
    chk("settle_len_ch1", settle_len, 16);
    wait_res(3, 320, 8, 0);
    chk("settle_len_ch3", settle_len, 16);
    wait_res(1, 160, 8, 0);
    wait_res(3, 320, 8, 0);
    chk("settle_len_ch3b", settle_len, 16);
    ch_mask = 4'b1111;
    silent  = 4'b0100;

    // Silent ch2 times out with nothing accumulated
    wait_res(0, 80, 8, 0);
    wait_res(1, 160, 8, 0);
    wait_res(2, 0, 0, 1);
    silent = 4'b0000;
    wait_res(3, 320, 8, 0);
    @(negedge clk);
    res_ready = 1'b0;

    // Back-pressure: result held, tags ignored, no new measurement
    wait_res(0, 80, 8, 0);
    spam = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_sum", res_sum, 80);
      chk("hold_ch", res_ch, 0);
      chk("hold_sel", ch_sel, 0);
    end
    spam = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", res_valid, 0);
    chk("post_hs_sel", ch_sel, 1);
    chk("post_hs_clear", det_clear, 1);

    // Disable mid-measurement: ch1 still reported, then IDLE
    wait_measure();
    enable = 1'b0;
    wait_res(1, 160, 8, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_clear", det_clear, 1);
      chk("idle_valid", res_valid, 0);
      chk("idle_sel", ch_sel, 1);
    end

    // Re-enable resumes after ch1; reset mid-MEASURE of ch2
    enable = 1'b1;
    @(negedge clk);
    wait_measure();
    chk("resume_sel", ch_sel, 2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // After reset the search restarts at ch0; single-bit mask re-measures ch2
    wait_res(0, 80, 8, 0);
    ch_mask = 4'b0100;
    wait_res(2, 240, 8, 0);
    use_seq = 1'b1;
    wait_res(2, 52, 8, 0);
`ifdef PHASE_SCHED_MINMAX_EN
    chk("res_min", res_min, 3);
    chk("res_max", res_max, 9);
`endif
    use_seq = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
